// File: rtl/ctrl_multiciclo.sv
// ctrl_multiciclo -- main control unit of a multicycle MIPS-style datapath.
//
// Moore FSM that sequences fetch, decode, address/ALU execute, memory access
// and write-back for lw/sw, R-type, I-type ALU, beq/bne, j/jal and jr.
// Adds supervision: a sticky illegal-opcode flag, a sticky memory-timeout
// flag driven by a per-access wait counter, and a retired-instruction count.
//
// Ports
//   Clock, Reset         : rising-edge clock, asynchronous active-high reset
//   OPCode, Func         : instruction[31:26] and instruction[5:0] from the IR
//   Zero_flag            : ALU zero result (branch resolution is done in the
//                          datapath through PCWriteCond/BranchNe)
//   MemReady             : memory has completed the current read/write
//   PCWrite..ALUSrcA     : 1-bit datapath strobes/selects
//   RegDst, ALUSrcB,
//   ALUSel, PCSource     : 2-bit datapath selects
//   State                : current state encoding (debug)
//   IllegalOp            : sticky, unsupported opcode seen in DECODE
//   MemTimeout           : sticky, a memory wait reached WAIT_MAX cycles
//   InstrCount           : retired instructions, wraps modulo 2^CNT_W
module ctrl_multiciclo #(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [5:0]       OPCode,
    input  logic [5:0]       Func,
    input  logic             Zero_flag,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             BranchNe,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       RegDst,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUSel,
    output logic [1:0]       PCSource,
    output logic [3:0]       State,
    output logic             IllegalOp,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] InstrCount
);

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADDR = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] EXEC_R  = 4'd6;
    localparam logic [3:0] RWB     = 4'd7;
    localparam logic [3:0] BRANCH  = 4'd8;
    localparam logic [3:0] JUMP    = 4'd9;
    localparam logic [3:0] EXEC_I  = 4'd10;
    localparam logic [3:0] IWB     = 4'd11;
    localparam logic [3:0] JR      = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam int WC_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(WAIT_MAX);

    logic [3:0]      state;
    logic [3:0]      next_state;
    logic [WC_W-1:0] wait_cnt;
    logic [WC_W-1:0] wait_cnt_nxt;
    logic            wait_state;
    logic            stalled;
    logic            illegal_hit;
    logic            retire;
    logic            zero_unused;

    // Branch resolution happens in the datapath; the flag is accepted only to
    // keep the interface complete.
    assign zero_unused = Zero_flag;

    assign State = state;

    // States that wait on the memory handshake.
    assign wait_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    assign stalled    = wait_state && !MemReady;

    always_comb begin
        next_state = state;
        case (state)
            FETCH:   next_state = MemReady ? DECODE : FETCH;
            DECODE: begin
                case (OPCode)
                    OP_RTYPE:                          next_state = (Func == FN_JR) ? JR : EXEC_R;
                    OP_LW, OP_SW:                      next_state = MEMADDR;
                    OP_BEQ, OP_BNE:                    next_state = BRANCH;
                    OP_J, OP_JAL:                      next_state = JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = EXEC_I;
                    default:                           next_state = FETCH;
                endcase
            end
            MEMADDR: next_state = (OPCode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   next_state = MemReady ? MEMWB : MEMRD;
            MEMWB:   next_state = FETCH;
            MEMWR:   next_state = MemReady ? FETCH : MEMWR;
            EXEC_R:  next_state = RWB;
            RWB:     next_state = FETCH;
            BRANCH:  next_state = FETCH;
            JUMP:    next_state = FETCH;
            EXEC_I:  next_state = IWB;
            IWB:     next_state = FETCH;
            JR:      next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    // DECODE only falls straight back to FETCH for an unsupported opcode.
    assign illegal_hit = (state == DECODE) && (next_state == FETCH);
    assign retire      = (state != FETCH) && (state != DECODE) && (next_state == FETCH);

    // The counter restarts whenever the state changes and saturates at WAIT_MAX;
    // reaching the limit only raises the flag, the FSM keeps waiting.
    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (next_state != state) begin
            wait_cnt_nxt = '0;
        end else if (stalled && (wait_cnt != WC_MAX)) begin
            wait_cnt_nxt = wait_cnt + WC_W'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= FETCH;
            wait_cnt   <= '0;
            IllegalOp  <= 1'b0;
            MemTimeout <= 1'b0;
            InstrCount <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_nxt;
            if (illegal_hit) begin
                IllegalOp <= 1'b1;
            end
            if (stalled && (wait_cnt_nxt == WC_MAX)) begin
                MemTimeout <= 1'b1;
            end
            if (retire) begin
                InstrCount <= InstrCount + CNT_W'(1);
            end
        end
    end

    // Output decode. Strobes are gated by Reset so nothing fires while the
    // controller is held, even though the held state is FETCH.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        RegDst      = 2'b00;
        ALUSrcB     = 2'b00;
        ALUSel      = 2'b00;
        PCSource    = 2'b00;
        if (!Reset) begin
            case (state)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    // IR and PC load only in the cycle the fetch completes.
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                end
                MEMADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUSel  = 2'b10;
                end
                RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b01;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUSel      = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    BranchNe    = OPCode[0];
                end
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                    if (OPCode == OP_JAL) begin
                        RegWrite = 1'b1;
                        RegDst   = 2'b10;
                    end
                end
                EXEC_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUSel  = 2'b11;
                end
                IWB: begin
                    RegWrite = 1'b1;
                end
                JR: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b11;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_multiciclo.sv
module tb_ctrl_multiciclo;

    localparam int WAIT_MAX = 15;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [5:0]  OPCode;
    logic [5:0]  Func;
    logic        Zero_flag;
    logic        MemReady;
    logic        PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite;
    logic        IRWrite, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0]  RegDst, ALUSrcB, ALUSel, PCSource;
    logic [3:0]  State;
    logic        IllegalOp, MemTimeout;
    logic [31:0] InstrCount;

    int total = 0;
    int bad   = 0;

    ctrl_multiciclo #(.CNT_W(32), .WAIT_MAX(WAIT_MAX)) dut (
        .Clock(Clock), .Reset(Reset), .OPCode(OPCode), .Func(Func),
        .Zero_flag(Zero_flag), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .RegDst(RegDst), .ALUSrcB(ALUSrcB), .ALUSel(ALUSel), .PCSource(PCSource),
        .State(State), .IllegalOp(IllegalOp), .MemTimeout(MemTimeout),
        .InstrCount(InstrCount)
    );

    always #5 Clock = ~Clock;

    logic [17:0] dut_outs;
    assign dut_outs = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
                       MemtoReg, RegWrite, ALUSrcA, RegDst, ALUSrcB, ALUSel, PCSource};

    // Reference: each instruction is a list of states walked one step per cycle;
    // memory states (0,3,5) repeat while MemReady is low.
    int          m_seq[$];
    int          m_idx;
    int          m_wc;
    bit          m_to, m_ill, m_this_illegal;
    int unsigned m_cnt;

    function automatic logic [17:0] exp_outs(int st, logic [5:0] op, logic mr);
        logic pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rw, srca;
        logic [1:0] rd, srcb, sel, pcs;
        {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rw, srca} = '0;
        rd = 2'b00; srcb = 2'b00; sel = 2'b00; pcs = 2'b00;
        case (st)
            0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            1:  srcb = 2'b11;
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin srca = 1; sel = 2'b10; end
            7:  begin rw = 1; rd = 2'b01; end
            8:  begin srca = 1; sel = 2'b01; pcwc = 1; pcs = 2'b01; bne = op[0]; end
            9:  begin pcw = 1; pcs = 2'b10; if (op == 6'b000011) begin rw = 1; rd = 2'b10; end end
            10: begin srca = 1; srcb = 2'b10; sel = 2'b11; end
            11: rw = 1;
            12: begin pcw = 1; pcs = 2'b11; end
            default: ;
        endcase
        return {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rw, srca, rd, srcb, sel, pcs};
    endfunction

    task automatic model_reset();
        m_seq = '{0, 1};
        m_idx = 0;
        m_wc = 0;
        m_to = 0;
        m_ill = 0;
        m_cnt = 0;
        m_this_illegal = 0;
    endtask

    task automatic chk(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model to the
    // state the DUT must reach at the coming rising edge.
    always @(negedge Clock) begin
        int cur;
        if (Reset) begin
            model_reset();
            chk("rst_state", State, 0);
            chk("rst_outs", dut_outs, 0);
            chk("rst_flags", {IllegalOp, MemTimeout}, 0);
            chk("rst_count", InstrCount, 0);
        end else begin
            cur = m_seq[m_idx];
            chk("state", State, cur);
            chk("outs", dut_outs, exp_outs(cur, OPCode, MemReady));
            chk("illegal", IllegalOp, m_ill);
            chk("timeout", MemTimeout, m_to);
            chk("count", InstrCount, m_cnt);
            if ((cur == 0 || cur == 3 || cur == 5) && !MemReady) begin
                if (m_wc < WAIT_MAX) m_wc++;
                if (m_wc == WAIT_MAX) m_to = 1;
            end else begin
                m_wc = 0;
                if (m_idx == 1) begin
                    case (OPCode)
                        6'b100011: begin m_seq.push_back(2); m_seq.push_back(3); m_seq.push_back(4); end
                        6'b101011: begin m_seq.push_back(2); m_seq.push_back(5); end
                        6'b000000: begin
                            if (Func == 6'b001000) m_seq.push_back(12);
                            else begin m_seq.push_back(6); m_seq.push_back(7); end
                        end
                        6'b000100, 6'b000101: m_seq.push_back(8);
                        6'b000010, 6'b000011: m_seq.push_back(9);
                        6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
                            m_seq.push_back(10); m_seq.push_back(11);
                        end
                        default: begin m_this_illegal = 1; m_ill = 1; end
                    endcase
                end
                m_idx++;
                if (m_idx == m_seq.size()) begin
                    if (!m_this_illegal) m_cnt++;
                    m_this_illegal = 0;
                    m_seq = '{0, 1};
                    m_idx = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    logic [5:0] op_pool [14] = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100,
                                 6'b000101, 6'b000010, 6'b000011, 6'b001000, 6'b001100,
                                 6'b001101, 6'b001010, 6'b111111, 6'b010001};

    initial begin
        Reset = 1; OPCode = 0; Func = 0; Zero_flag = 0; MemReady = 0;
        step();
        #1;
        chk("lit_rst_state", State, 0);
        chk("lit_rst_memread", MemRead, 0);
        step();

        // lw with MemReady high: 0,1,2,3,4,0
        Reset = 0; OPCode = 6'b100011; MemReady = 1;
        #1 chk("lw_s0", State, 0);
        step(); #1 chk("lw_s1", State, 1);
        step(); #1 chk("lw_s2", State, 2);
        step(); #1 chk("lw_s3", State, 3);
        step(); #1 chk("lw_s4", State, 4);
        chk("lw_wb", {RegWrite, MemtoReg}, 2'b11);
        step(); #1 chk("lw_end", State, 0);
        chk("lw_cnt", InstrCount, 1);

        // sw with three stalled cycles in MEMWR
        OPCode = 6'b101011;
        step(); step(); step();
        MemReady = 0;
        #1 chk("sw_s5", State, 5);
        for (int i = 0; i < 3; i++) begin
            chk("sw_mw", MemWrite, 1);
            step();
        end
        MemReady = 1;
        #1 chk("sw_mw4", {State, MemWrite}, {4'd5, 1'b1});
        step(); #1 chk("sw_end", State, 0);
        chk("sw_cnt", InstrCount, 2);

        // bne
        OPCode = 6'b000101;
        step(); step(); #1
        chk("bne", {State, PCWriteCond, BranchNe, PCSource}, {4'd8, 1'b1, 1'b1, 2'b01});
        step();
        // jal
        OPCode = 6'b000011;
        step(); step(); #1
        chk("jal", {State, PCWrite, RegDst, RegWrite}, {4'd9, 1'b1, 2'b10, 1'b1});
        step(); #1 chk("jal_cnt", InstrCount, 4);

        // illegal opcode
        OPCode = 6'b111111;
        step(); #1 chk("ill_pre", {State, IllegalOp}, {4'd1, 1'b0});
        step(); #1 chk("ill_post", {State, IllegalOp}, {4'd0, 1'b1});
        chk("ill_cnt", InstrCount, 4);

        // fetch timeout
        MemReady = 0;
        for (int i = 1; i <= 20; i++) begin
            step(); #1
            chk("to_flag", MemTimeout, (i >= WAIT_MAX) ? 1 : 0);
        end
        chk("to_state", State, 0);
        Reset = 1;
        #1 chk("to_clear", {MemTimeout, IllegalOp}, 0);
        step();
        Reset = 0; MemReady = 1;

        // reset in the middle of a load wait
        OPCode = 6'b100011;
        step(); step(); step();
        MemReady = 0;
        #1 chk("rd_s3", State, 3);
        step();
        Reset = 1;
        #1 chk("rd_rst", {State, MemRead, RegWrite}, 0);
        step();
        Reset = 0; MemReady = 1;
        #1 chk("rd_release", {State, MemRead}, {4'd0, 1'b1});

        // randomized run
        for (int c = 0; c < 4000; c++) begin
            step();
            if (Reset) Reset = 0;
            else if ($urandom_range(0, 249) == 0) Reset = 1;
            MemReady = ($urandom_range(0, 9) < 7);
            Zero_flag = $urandom_range(0, 1);
            if (m_seq[m_idx] == 0) begin
                OPCode = op_pool[$urandom_range(0, 13)];
                Func = ($urandom_range(0, 1) == 1) ? 6'b001000 : 6'($urandom_range(0, 63));
            end
        end
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_multiciclo.md
CTRL_MULTICICLO -- requirements
Module: ctrl_multiciclo

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 SHALL have parameter WAIT_MAX, default 15: maximum MemReady wait cycles before the timeout flag is raised.
REQ-003 SHALL have port Clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port OPCode, input, 6: instruction[31:26] taken from the instruction register.
REQ-006 SHALL have port Func, input, 6: instruction[5:0].
REQ-007 SHALL have port Zero_flag, input, 1: ALU zero result.
REQ-008 SHALL have port MemReady, input, 1: the memory has completed the current read or write.
REQ-009 SHALL have the following 1-bit outputs:
- PCWrite, PCWriteCond
- BranchNe: 1 = bne, 0 = beq
- IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite
- ALUSrcA: 0 = PC, 1 = rs
REQ-010 SHALL have the following 2-bit outputs:
- RegDst: 00 rt, 01 rd, 10 reg31
- ALUSrcB: 00 B, 01 const 4, 10 sign-extended, 11 sign-extended<<2
- ALUSel: 00 add, 01 sub, 10 funct-decoded, 11 opcode-decoded
- PCSource: 00 ALU result, 01 ALUOut, 10 jump target, 11 rs
REQ-011 SHALL have output State, 4 bits, exposing the current state encoding for debug.
REQ-012 SHALL have output IllegalOp, 1 bit: sticky flag for an unsupported opcode.
REQ-013 SHALL have output MemTimeout, 1 bit: sticky flag for a memory wait that exceeded WAIT_MAX.
REQ-014 SHALL have output InstrCount, CNT_W bits: number of retired instructions.

Function
REQ-015 SHALL implement a Moore FSM with these encodings:
- FETCH=0, DECODE=1, MEMADDR=2, MEMRD=3, MEMWB=4, MEMWR=5
- EXEC_R=6, RWB=7, BRANCH=8, JUMP=9, EXEC_I=10, IWB=11, JR=12
REQ-016 FETCH outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUSel=00, PCSource=00. IRWrite=1 and PCWrite=1 only in the cycle MemReady=1; otherwise stay in FETCH.
REQ-017 DECODE outputs: ALUSrcA=0, ALUSrcB=11, ALUSel=00 (precompute the branch target). Next state by OPCode:
- 000000 -> JR if Func=001000, else EXEC_R
- 100011 or 101011 -> MEMADDR
- 000100 or 000101 -> BRANCH
- 000010 or 000011 -> JUMP
- 001000, 001100, 001101, 001010 -> EXEC_I
- any other -> FETCH with IllegalOp set and InstrCount not incremented
REQ-018 MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUSel=00. Next state MEMRD for opcode 100011, MEMWR for 101011.
REQ-019 MEMRD: MemRead=1, IorD=1; hold until MemReady=1, then go to MEMWB.
REQ-020 MEMWB: RegWrite=1, MemtoReg=1, RegDst=00; then FETCH.
REQ-021 MEMWR: MemWrite=1, IorD=1; hold until MemReady=1, then FETCH.
REQ-022 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUSel=10; then RWB.
REQ-023 RWB: RegWrite=1, RegDst=01, MemtoReg=0; then FETCH.
REQ-024 EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUSel=11; then IWB.
REQ-025 IWB: RegWrite=1, RegDst=00; then FETCH.
REQ-026 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUSel=01, PCWriteCond=1, PCSource=01, BranchNe=OPCode[0]; then FETCH.
REQ-027 JUMP: PCWrite=1, PCSource=10. For opcode 000011 also RegWrite=1 and RegDst=10 (link value supplied by the datapath); then FETCH.
REQ-028 JR: PCWrite=1, PCSource=11; then FETCH.
REQ-029 Outputs not listed for a state SHALL be 0.
REQ-030 The wait counter SHALL:
- clear on entry to FETCH, MEMRD or MEMWR
- increment on each cycle MemReady=0 in those states
- when it reaches WAIT_MAX, set MemTimeout and hold the FSM in its state (no abort)
REQ-031 A MemReady pulse in any state other than FETCH, MEMRD or MEMWR SHALL be ignored.
REQ-032 InstrCount SHALL increment by 1 on every transition into FETCH from a non-FETCH state, except the illegal-opcode path, and SHALL wrap modulo 2^CNT_W.
REQ-033 Instruction latencies with MemReady constantly 1:
- 5 cycles: lw
- 4 cycles: sw, R-type, I-type
- 3 cycles: beq, bne, j, jal, jr

Reset
REQ-034 While Reset=1, State SHALL be FETCH, every strobe output SHALL be forced to 0, and IllegalOp, MemTimeout, InstrCount and the wait counter SHALL be 0.
REQ-035 Reset asserted in any state, including mid-wait, SHALL abort that instruction without a trailing write. FETCH outputs SHALL appear in the first cycle after release.

Verification
REQ-036 lw (100011) with MemReady=1 throughout -> State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; InstrCount 0->1.
REQ-037 sw with MemReady held 0 for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, then State=0, RegWrite never 1.
REQ-038 bne (000101) -> BRANCH shows PCWriteCond=1, BranchNe=1, PCSource=01; jal (000011) -> JUMP shows PCWrite=1, RegDst=10, RegWrite=1.
REQ-039 OPCode=111111 in DECODE -> IllegalOp=1 next cycle, State=0, InstrCount unchanged.
REQ-040 MemReady=0 for 20 cycles in FETCH -> MemTimeout=1 after the 15th wait cycle; State remains 0; Reset pulse -> MemTimeout=0.
REQ-041 Reset asserted during MEMRD -> State=0 immediately, MemRead=0 while Reset=1, no RegWrite pulse.
